// File: rtl/imsai_uart_pkg.sv
// Shared UART definitions for the IMSAI board (receiver, transmitter, divider).
package imsai_uart_pkg;

  // 50 MHz / 115200 baud
  localparam int UART_CLKS_PER_BIT_DEFAULT = 434;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } uart_rx_state_t;

endpackage

// File: rtl/uart_rx_if.sv
// Holding-register handshake between the receiver and the S100 I/O logic.
interface uart_rx_if;
  logic [7:0] o_data;
  logic       o_data_valid;
  logic       i_data_rd;
  logic       o_frame_err;
  logic       o_overrun;
  logic       i_err_clr;

  modport master (
    output o_data, o_data_valid, o_frame_err, o_overrun,
    input  i_data_rd, i_err_clr
  );

  modport slave (
    input  o_data, o_data_valid, o_frame_err, o_overrun,
    output i_data_rd, i_err_clr
  );
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer; resets to 1 so an idle-high line reads idle in reset.
module sync_2ff (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_d,
  output logic o_q
);
  logic [1:0] sync_q;

  // shift the asynchronous input through two flops
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) sync_q <= 2'b11;
    else            sync_q <= {sync_q[0], i_d};
  end

  assign o_q = sync_q[1];
endmodule

// File: rtl/uart_rx.sv
// 8N1 serial receiver with one-byte holding register, framing and overrun flags.
module uart_rx
  import imsai_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT
) (
  input  logic      i_clk,
  input  logic      i_reset_n,
  input  logic      i_uart_rx,
  uart_rx_if.master bus
);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_HALF = BW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] BAUD_FULL = BW'(CLKS_PER_BIT - 1);

  logic           rx_s;
  uart_rx_state_t state_q, state_d;
  logic [BW-1:0]  baud_q, baud_d;
  logic [2:0]     bit_q, bit_d;
  logic [7:0]     shift_q, shift_d;
  logic [7:0]     data_q, data_d;
  logic           valid_q, valid_d;
  logic           ferr_q, ferr_d;
  logic           ovr_q, ovr_d;
  logic           deliver, ferr_set;
  logic           baud_zero;

  sync_2ff u_sync (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_d       (i_uart_rx),
    .o_q       (rx_s)
  );

  assign baud_zero = (baud_q == '0);

  // state register
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) state_q <= IDLE;
    else            state_q <= state_d;
  end

  // next-state: every decision is taken at a mid-bit sample point
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!rx_s) state_d = START;
      START:   if (baud_zero) state_d = rx_s ? IDLE : DATA;
      DATA:    if (baud_zero && bit_q == 3'd7) state_d = STOP;
      STOP:    if (baud_zero) state_d = rx_s ? IDLE : BREAK;
      BREAK:   if (rx_s) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: baud/bit counters, shifter, delivery and framing-error pulses
  always_comb begin
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    deliver  = 1'b0;
    ferr_set = 1'b0;
    case (state_q)
      IDLE: if (!rx_s) begin
        bit_d  = 3'd0;
        baud_d = BAUD_HALF;
      end
      START: begin
        if (!baud_zero)  baud_d = baud_q - BW'(1);
        else if (!rx_s)  baud_d = BAUD_FULL;
      end
      DATA: begin
        if (baud_zero) begin
          shift_d = {rx_s, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          baud_d  = BAUD_FULL;
        end else begin
          baud_d = baud_q - BW'(1);
        end
      end
      STOP: begin
        if (baud_zero) begin
          deliver  = rx_s;
          ferr_set = ~rx_s;
        end else begin
          baud_d = baud_q - BW'(1);
        end
      end
      default: ;
    endcase
  end

  // holding register and sticky flags; delivery beats read, set beats clear
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q & ~bus.i_data_rd;
    ferr_d  = (ferr_q & ~bus.i_err_clr) | ferr_set;
    ovr_d   = ovr_q & ~bus.i_err_clr;
    if (deliver) begin
      if (!valid_q || bus.i_data_rd) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  // datapath registers
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign bus.o_data       = data_q;
  assign bus.o_data_valid = valid_q;
  assign bus.o_frame_err  = ferr_q;
  assign bus.o_overrun    = ovr_q;
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: single-frame vector table plus corner sequences.
module tb_uart_rx;
  localparam int CPB = 434;
  localparam int LAT = 2 + CPB / 2 + 9 * CPB + 1;  // pin fall -> valid rise

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic rx    = 1'b1;

  uart_rx_if bus ();

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .i_uart_rx (rx),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   rise_cyc = 0;
  int   last_t0 = 0;
  int   t1;
  logic v_prev = 1'b0;

  // cycle counter and valid rising-edge timestamp
  always @(posedge clk) begin
    cyc    <= cyc + 1;
    v_prev <= bus.o_data_valid;
    if (bus.o_data_valid && !v_prev) rise_cyc <= cyc;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  typedef struct {
    logic [7:0] d;
    logic       stop;
    int         hold_bits;
    logic       chk_lat;
    logic       exp_v;
    logic [7:0] exp_d;
    logic       exp_fe;
    logic       exp_ov;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // called #1 after an edge; returns #1 after the edge ending the stop bit
  task automatic send_frame(input logic [7:0] d, input logic stop);
    logic [9:0] bits;
    bits    = {stop, d, 1'b0};
    last_t0 = cyc;
    for (int b = 0; b < 10; b++) begin
      rx = bits[b];
      idle(CPB);
    end
  endtask

  task automatic pulse_clr();
    bus.i_data_rd = 1'b1;
    bus.i_err_clr = 1'b1;
    idle(1);
    bus.i_data_rd = 1'b0;
    bus.i_err_clr = 1'b0;
  endtask

  initial begin
    logic [7:0] part;
    int k;
    bus.i_data_rd = 1'b0;
    bus.i_err_clr = 1'b0;

    vecs[0] = '{8'hA5, 1'b1, 0,  1'b1, 1'b1, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{8'h3C, 1'b0, 20, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'h55, 1'b1, 0,  1'b0, 1'b1, 8'h55, 1'b0, 1'b0};
    vecs[3] = '{8'hC3, 1'b1, 0,  1'b0, 1'b1, 8'hC3, 1'b0, 1'b0};

    idle(3);
    chk("rst_data",  bus.o_data, 8'h00);
    chk("rst_valid", bus.o_data_valid, 1'b0);
    chk("rst_ferr",  bus.o_frame_err, 1'b0);
    chk("rst_ovr",   bus.o_overrun, 1'b0);
    rst_n = 1'b1;
    idle(5);

    // single frames from the table
    for (int i = 0; i < 4; i++) begin
      send_frame(vecs[i].d, vecs[i].stop);
      if (vecs[i].hold_bits > 0) idle(vecs[i].hold_bits * CPB);
      rx = 1'b1;
      idle(2 * CPB);
      chk($sformatf("v%0d_valid", i), bus.o_data_valid, vecs[i].exp_v);
      if (vecs[i].exp_v) chk($sformatf("v%0d_data", i), bus.o_data, vecs[i].exp_d);
      chk($sformatf("v%0d_ferr", i), bus.o_frame_err, vecs[i].exp_fe);
      chk($sformatf("v%0d_ovr", i),  bus.o_overrun, vecs[i].exp_ov);
      if (vecs[i].chk_lat) chk($sformatf("v%0d_latency", i), rise_cyc - last_t0, LAT);
      pulse_clr();
      chk($sformatf("v%0d_clr_valid", i), bus.o_data_valid, 1'b0);
      chk($sformatf("v%0d_clr_ferr", i),  bus.o_frame_err, 1'b0);
    end

    // short low glitch must be rejected at the start-bit sample
    rx = 1'b0;
    idle(100);
    rx = 1'b1;
    idle(12 * CPB);
    chk("glitch_valid", bus.o_data_valid, 1'b0);
    chk("glitch_ferr",  bus.o_frame_err, 1'b0);

    // back-to-back without reading: second byte dropped, overrun set
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    idle(CPB);
    chk("ovr_data",  bus.o_data, 8'h11);
    chk("ovr_valid", bus.o_data_valid, 1'b1);
    chk("ovr_flag",  bus.o_overrun, 1'b1);
    chk("ovr_ferr",  bus.o_frame_err, 1'b0);
    bus.i_data_rd = 1'b1;
    idle(1);
    bus.i_data_rd = 1'b0;
    chk("rd_valid", bus.o_data_valid, 1'b0);
    chk("rd_keeps_ovr", bus.o_overrun, 1'b1);
    bus.i_err_clr = 1'b1;
    idle(1);
    bus.i_err_clr = 1'b0;
    chk("clr_ovr", bus.o_overrun, 1'b0);

    // read strobe in the exact delivery cycle of the second byte
    send_frame(8'h00, 1'b1);
    t1 = cyc;
    fork
      send_frame(8'hFF, 1'b1);
      begin
        k = 0;
        while (cyc != t1 + LAT - 1 && k < 20 * CPB) begin
          idle(1);
          k++;
        end
        chk("same_wait", (k < 20 * CPB), 1'b1);
        chk("same_pre_valid", bus.o_data_valid, 1'b1);
        chk("same_pre_data",  bus.o_data, 8'h00);
        bus.i_data_rd = 1'b1;
        idle(1);
        bus.i_data_rd = 1'b0;
        chk("same_valid", bus.o_data_valid, 1'b1);
        chk("same_data",  bus.o_data, 8'hFF);
        chk("same_ovr",   bus.o_overrun, 1'b0);
      end
    join

    // reset in the middle of data bit 4
    part = 8'h5A;
    rx = 1'b0;
    idle(CPB);
    for (int b = 0; b < 4; b++) begin
      rx = part[b];
      idle(CPB);
    end
    rx = part[4];
    idle(CPB / 2);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_data",  bus.o_data, 8'h00);
    chk("mid_rst_valid", bus.o_data_valid, 1'b0);
    chk("mid_rst_ferr",  bus.o_frame_err, 1'b0);
    chk("mid_rst_ovr",   bus.o_overrun, 1'b0);
    rx = 1'b1;
    idle(3);
    rst_n = 1'b1;
    idle(2 * CPB);
    send_frame(8'h81, 1'b1);
    chk("post_rst_data",  bus.o_data, 8'h81);
    chk("post_rst_valid", bus.o_data_valid, 1'b1);
    chk("post_rst_ferr",  bus.o_frame_err, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
